// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: memory-wait freeze, branch flush and load-use stall arbitration.
// Optional statistics counters are built only when the STALL_STATS_EN macro is defined.
module pipeline_stall_controller #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             stats_clr,
    output logic             freeze_front,
    output logic             freeze_back,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] wait_cnt_r;
    logic [7:0] wait_cnt_nxt_s;

    logic freeze_front_s;
    logic freeze_back_s;
    logic flush_if_id_s;
    logic flush_id_exe_s;
    logic mem_error_s;

    // Branch flush beats the load-use stall; returns {freeze_front, flush_if_id, flush_id_exe}.
    function automatic logic [2:0] front_decode(input logic branch, input logic hazard);
        logic [2:0] res;
        if (branch) begin
            res = 3'b011;
        end else if (hazard) begin
            res = 3'b101;
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    // State and wait-counter registers; reset always lands in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Mealy next-state and control decode; memory stall outranks every front-end action.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        freeze_front_s = 1'b0;
        freeze_back_s  = 1'b0;
        flush_if_id_s  = 1'b0;
        flush_id_exe_s = 1'b0;
        mem_error_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze_front_s = 1'b1;
                    freeze_back_s  = 1'b1;
                    state_nxt_s    = ST_MEM_WAIT;
                    wait_cnt_nxt_s = 8'd1;
                end else begin
                    {freeze_front_s, flush_if_id_s, flush_id_exe_s} =
                        front_decode(branch_taken, hazard_detected);
                    wait_cnt_nxt_s = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                // Only mem_ready ends the wait; a dropped mem_req is deliberately ignored.
                if (mem_ready) begin
                    {freeze_front_s, flush_if_id_s, flush_id_exe_s} =
                        front_decode(branch_taken, hazard_detected);
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = 8'd0;
                end else begin
                    freeze_front_s = 1'b1;
                    freeze_back_s  = 1'b1;
                    if (wait_cnt_r == TIMEOUT_C) begin
                        state_nxt_s    = ST_ERROR;
                        wait_cnt_nxt_s = 8'd0;
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                    end
                end
            end
            ST_ERROR: begin
                freeze_front_s = 1'b1;
                freeze_back_s  = 1'b1;
                mem_error_s    = 1'b1;
            end
            default: begin
                state_nxt_s    = ST_RUN;
                wait_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    assign freeze_front = freeze_front_s;
    assign freeze_back  = freeze_back_s;
    assign flush_if_id  = flush_if_id_s;
    assign flush_id_exe = flush_id_exe_s;
    assign mem_error    = mem_error_s;

`ifdef STALL_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_count_r;
    logic [CNT_W-1:0] flush_count_r;

    // Saturating event counters; a clear request wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_r <= '0;
            flush_count_r <= '0;
        end else if (stats_clr) begin
            stall_count_r <= '0;
            flush_count_r <= '0;
        end else begin
            if (freeze_front_s && (stall_count_r != CNT_MAX_C)) begin
                stall_count_r <= stall_count_r + CNT_W'(1);
            end else begin
                stall_count_r <= stall_count_r;
            end
            if (flush_if_id_s && (flush_count_r != CNT_MAX_C)) begin
                flush_count_r <= flush_count_r + CNT_W'(1);
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end

    assign stall_count = stall_count_r;
    assign flush_count = flush_count_r;
`else
    logic stats_clr_unused_s;

    assign stats_clr_unused_s = stats_clr;
    assign stall_count        = '0;
    assign flush_count        = '0;
`endif

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, max memory-wait cycles before fault; legal range 1..255.
REQ-002 Parameter CNT_W, default 16, width of statistics counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 hazard_detected  input  1  load-use hazard flag from the hazard detection unit (ID stage).
REQ-006 branch_taken  input  1  taken branch resolved in EXE stage.
REQ-007 mem_req  input  1  MEM stage issuing a data-memory access this cycle.
REQ-008 mem_ready  input  1  data memory completes access this cycle.
REQ-009 stats_clr  input  1  synchronous clear of statistics counters.
REQ-010 freeze_front  output  1  hold PC and IF/ID register.
REQ-011 freeze_back  output  1  hold ID/EXE, EXE/MEM, MEM/WB registers.
REQ-012 flush_if_id  output  1  load NOP into IF/ID.
REQ-013 flush_id_exe  output  1  load bubble into ID/EXE.
REQ-014 mem_error  output  1  memory-timeout fault, sticky.
REQ-015 stall_count  output  CNT_W  cycles with freeze_front=1.
REQ-016 flush_count  output  CNT_W  cycles with flush_if_id=1.

Function
REQ-017 States: RUN, MEM_WAIT, ERROR; state and 8-bit wait counter are the only control registers.
REQ-018 Control outputs are Mealy: combinational from current state and inputs, same-cycle effect, zero latency.
REQ-019 RUN, mem_req=1, mem_ready=0: freeze_front=1, freeze_back=1, flushes=0; next MEM_WAIT, wait counter <= 1.
REQ-020 RUN, memory not stalling, branch_taken=1: flush_if_id=1, flush_id_exe=1, freezes=0; hazard_detected ignored.
REQ-021 RUN, memory not stalling, branch_taken=0, hazard_detected=1: freeze_front=1, flush_id_exe=1, freeze_back=0, flush_if_id=0.
REQ-022 RUN, no condition active: all control outputs 0; state stays RUN.
REQ-023 Priority: memory stall > branch flush > load-use stall; flush outputs never asserted while freeze_back=1.
REQ-024 MEM_WAIT, mem_ready=0: freeze_front=1, freeze_back=1; wait counter increments.
REQ-025 MEM_WAIT, mem_ready=1: all freezes 0 that cycle, branch/hazard rules of REQ-020/021 apply; next RUN, counter cleared.
REQ-026 MEM_WAIT, mem_ready=0, wait counter == MEM_TIMEOUT: next ERROR.
REQ-027 ERROR: freeze_front=1, freeze_back=1, flushes=0, mem_error=1; exit only by reset.
REQ-028 mem_req deasserting in MEM_WAIT is ignored; only mem_ready ends the wait.

Reset
REQ-029 rst=0 asynchronously forces state RUN, wait counter 0, mem_error 0, stall_count 0, flush_count 0.
REQ-030 During reset, all control outputs evaluate as RUN with inputs; reset mid-MEM_WAIT or in ERROR returns to RUN on next edge after release with no residual freeze.

Configuration
REQ-031 Macro STALL_STATS_EN defined: stall_count/flush_count increment per REQ-015/016, saturate at 2^CNT_W-1, stats_clr=1 zeroes them next edge (clear wins over increment).
REQ-032 STALL_STATS_EN undefined: ports remain, driven constant 0, no counter registers; stats_clr ignored.

Verification
REQ-033 RUN, hazard_detected=1 one cycle -> same cycle freeze_front=1, flush_id_exe=1, freeze_back=0; next cycle all 0; stall_count=1 (stats on).
REQ-034 branch_taken=1 and hazard_detected=1 together -> flush_if_id=1, flush_id_exe=1, freeze_front=0; flush_count=1.
REQ-035 mem_req=1, mem_ready low 3 cycles then high, branch_taken=1 throughout -> 3 cycles full freeze no flushes, 4th cycle flushes only, state RUN after.
REQ-036 MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 -> freeze 5 cycles, mem_error=1 from 6th cycle, persists until rst=0, then all outputs 0.
REQ-037 Stats on, CNT_W=4, hazard held 20 cycles -> stall_count saturates at 15; stats_clr=1 -> 0 next cycle; macro off -> counts stay 0.
